// File: rtl/lsu_if.sv
// LSU port bundle: EXE issue/result, ROB commit/flush,
// and the data memory request/response channel.
interface lsu_if;
  logic        ld_i_valid;
  logic        st_i_valid;
  logic [2:0]  lsu_i_rob_idx;
  logic [31:0] lsu_i_rs1_data;
  logic [31:0] lsu_i_rs2_data;
  logic [31:0] lsu_i_imm;
  logic [2:0]  lsu_i_f3;
  logic [6:0]  lsu_i_rd;
  logic        ld_i_ready;
  logic        st_i_ready;
  logic        ld_o_valid;
  logic [2:0]  ld_o_rob_idx;
  logic [6:0]  ld_o_rd;
  logic [31:0] ld_o_data;
  logic        ld_o_ready;
  logic        st_commit;
  logic        flush;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  modport slave (
    input  ld_i_valid, st_i_valid, lsu_i_rob_idx,
    input  lsu_i_rs1_data, lsu_i_rs2_data, lsu_i_imm,
    input  lsu_i_f3, lsu_i_rd, ld_o_ready,
    input  st_commit, flush,
    input  dm_gnt, dm_rvalid, dm_rdata,
    output ld_i_ready, st_i_ready,
    output ld_o_valid, ld_o_rob_idx, ld_o_rd, ld_o_data,
    output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata
  );

  modport master (
    output ld_i_valid, st_i_valid, lsu_i_rob_idx,
    output lsu_i_rs1_data, lsu_i_rs2_data, lsu_i_imm,
    output lsu_i_f3, lsu_i_rd, ld_o_ready,
    output st_commit, flush,
    output dm_gnt, dm_rvalid, dm_rdata,
    input  ld_i_ready, st_i_ready,
    input  ld_o_valid, ld_o_rob_idx, ld_o_rd, ld_o_data,
    input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: commit-gated store buffer with store-to-load
// forwarding and a single in-flight load sharing one memory port.
module lsu #(
  parameter int SB_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  lsu_if.slave bus
);
  localparam int IW = $clog2(SB_DEPTH);
  localparam int PW = IW + 1;

  typedef enum logic [2:0] {
    IDLE, CHECK, REQ, WAIT, RESP, DROP
  } ld_state_t;

  logic [29:0]   sb_addr [SB_DEPTH];
  logic [31:0]   sb_data [SB_DEPTH];
  logic [3:0]    sb_strb [SB_DEPTH];
  logic [PW-1:0] head, tail, cmt, count;
  logic          full, drain_ok, enq, pop, ld_acc;
  logic [31:0]   eff;
  ld_state_t     state, state_nx;
  logic [31:0]   ld_addr, res_data;
  logic [2:0]    ld_f3, ld_rob;
  logic [6:0]    ld_rd;
  logic [3:0]    ld_need, fwd_strb;
  logic [31:0]   fwd_word;
  logic          hit, fwd_ok;
  logic          hold, hold_we, sel_rd, sel_wr;

  function automatic logic [3:0] lane_mask(
    input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   lane_mask = 4'b0001 << a;
      2'b01:   lane_mask = 4'b0011 << a;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extract(
    input logic [31:0] w, input logic [1:0] a,
    input logic [2:0] f3);
    logic [31:0] s;
    s = w >> {a, 3'b000};
    case (f3)
      3'b000:  extract = {{24{s[7]}}, s[7:0]};
      3'b001:  extract = {{16{s[15]}}, s[15:0]};
      3'b100:  extract = {24'd0, s[7:0]};
      3'b101:  extract = {16'd0, s[15:0]};
      default: extract = s;
    endcase
  endfunction

  assign eff      = bus.lsu_i_rs1_data + bus.lsu_i_imm;
  assign count    = tail - head;
  assign full     = count == PW'(SB_DEPTH);
  assign drain_ok = cmt != head;
  assign enq      = bus.st_i_valid & ~full & ~bus.flush;
  assign ld_acc   = bus.ld_i_valid & (state == IDLE)
                  & ~bus.flush;
  assign pop      = sel_wr & bus.dm_gnt;
  assign ld_need  = lane_mask(ld_f3[1:0], ld_addr[1:0]);

  assign bus.st_i_ready   = ~full;
  assign bus.ld_i_ready   = state == IDLE;
  assign bus.ld_o_valid   = state == RESP;
  assign bus.ld_o_rob_idx = ld_rob;
  assign bus.ld_o_rd      = ld_rd;
  assign bus.ld_o_data    = res_data;

  // Store buffer payload; tail slot written on enqueue.
  always_ff @(posedge clk) begin
    if (enq) begin
      sb_addr[tail[IW-1:0]] <= eff[31:2];
      sb_data[tail[IW-1:0]] <=
        bus.lsu_i_rs2_data << {eff[1:0], 3'b000};
      sb_strb[tail[IW-1:0]] <=
        lane_mask(bus.lsu_i_f3[1:0], eff[1:0]);
    end
  end

  // Pointers; flush rolls tail back to the post-commit cmt.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cmt  <= '0;
    end else begin
      if (pop) head <= head + PW'(1);
      cmt <= cmt + PW'(bus.st_commit);
      if (bus.flush) tail <= cmt + PW'(bus.st_commit);
      else           tail <= tail + PW'(enq);
    end
  end

  // Memory port arbitration; a pending request is never switched.
  always_comb begin
    sel_rd = 1'b0;
    sel_wr = 1'b0;
    if (hold) begin
      sel_wr = hold_we;
      sel_rd = ~hold_we & (state == REQ);
    end else begin
      sel_rd = (state == REQ) & ~(full & drain_ok);
      sel_wr = drain_ok & ~sel_rd;
    end
  end

  assign bus.dm_req   = sel_rd | sel_wr;
  assign bus.dm_we    = sel_wr;
  assign bus.dm_addr  =
    sel_wr ? {sb_addr[head[IW-1:0]], 2'b00} :
    sel_rd ? {ld_addr[31:2], 2'b00} : 32'd0;
  assign bus.dm_wstrb = sel_wr ? sb_strb[head[IW-1:0]] : 4'd0;
  assign bus.dm_wdata = sel_wr ? sb_data[head[IW-1:0]] : 32'd0;

  // Remember an ungranted request so its fields stay put.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold    <= 1'b0;
      hold_we <= 1'b0;
    end else begin
      hold    <= bus.dm_req & ~bus.dm_gnt
               & (bus.dm_we | ~bus.flush);
      hold_we <= bus.dm_we;
    end
  end

  // Youngest word-address match among live buffer entries.
  always_comb begin
    hit      = 1'b0;
    fwd_strb = '0;
    fwd_word = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (PW'(i) < count &&
          sb_addr[head[IW-1:0] + IW'(i)] == ld_addr[31:2]) begin
        hit      = 1'b1;
        fwd_strb = sb_strb[head[IW-1:0] + IW'(i)];
        fwd_word = sb_data[head[IW-1:0] + IW'(i)];
      end
    end
    fwd_ok = hit & ((fwd_strb & ld_need) == ld_need);
  end

  // Load FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Load FSM next state; flush kills all but an in-flight read.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (ld_acc) state_nx = CHECK;
      CHECK: begin
        if (fwd_ok)    state_nx = RESP;
        else if (!hit) state_nx = REQ;
      end
      REQ:   if (sel_rd & bus.dm_gnt) state_nx = WAIT;
      WAIT:  if (bus.dm_rvalid) state_nx = RESP;
      RESP:  if (bus.ld_o_ready) state_nx = IDLE;
      DROP:  if (bus.dm_rvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush) begin
      if ((state == WAIT || state == DROP) && !bus.dm_rvalid)
        state_nx = DROP;
      else
        state_nx = IDLE;
    end
  end

  // Load context and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_addr  <= '0;
      ld_f3    <= '0;
      ld_rd    <= '0;
      ld_rob   <= '0;
      res_data <= '0;
    end else begin
      if (ld_acc) begin
        ld_addr <= eff;
        ld_f3   <= bus.lsu_i_f3;
        ld_rd   <= bus.lsu_i_rd;
        ld_rob  <= bus.lsu_i_rob_idx;
      end
      if (state == CHECK && fwd_ok)
        res_data <= extract(fwd_word, ld_addr[1:0], ld_f3);
      else if (state == WAIT && bus.dm_rvalid)
        res_data <= extract(bus.dm_rdata, ld_addr[1:0], ld_f3);
    end
  end
endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: load results and memory writes are
// queued when stimulus is driven and compared as they appear.
module tb_lsu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_if bus();
  lsu #(.SB_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [2:0]  rob;
    logic [6:0]  rd;
    logic [31:0] data;
  } ld_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } wr_t;

  int checks = 0;
  int failures = 0;
  ld_t exp_q[$];
  wr_t wr_q[$];
  wr_t wexp_q[$];
  logic [31:0] mem [int];
  int gnt_budget = 0;
  int rd_lat = 1;
  int rd_cnt = 0;
  int rd_total = 0;
  logic [31:0] rd_word;

  // Data memory model: grants while budget lasts, read data after rd_lat.
  initial begin : memory
    int widx;
    logic [31:0] w;
    bus.dm_gnt = 0;
    bus.dm_rvalid = 0;
    bus.dm_rdata = 0;
    forever begin
      @(negedge clk);
      bus.dm_gnt = 0;
      bus.dm_rvalid = 0;
      if (rst) begin
        rd_cnt = 0;
        continue;
      end
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          bus.dm_rvalid = 1;
          bus.dm_rdata = rd_word;
        end
      end
      if (bus.dm_req && gnt_budget > 0) begin
        gnt_budget--;
        bus.dm_gnt = 1;
        widx = int'(bus.dm_addr[31:2]);
        w = mem.exists(widx) ? mem[widx] : 32'd0;
        if (bus.dm_we) begin
          for (int b = 0; b < 4; b++)
            if (bus.dm_wstrb[b]) w[8*b +: 8] = bus.dm_wdata[8*b +: 8];
          mem[widx] = w;
          wr_q.push_back('{bus.dm_addr, bus.dm_wstrb, bus.dm_wdata});
        end else begin
          rd_word = w;
          rd_cnt = rd_lat;
          rd_total++;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    bus.ld_i_valid = 0;
    bus.st_i_valid = 0;
    bus.lsu_i_rob_idx = 0;
    bus.lsu_i_rs1_data = 0;
    bus.lsu_i_rs2_data = 0;
    bus.lsu_i_imm = 0;
    bus.lsu_i_f3 = 0;
    bus.lsu_i_rd = 0;
    bus.ld_o_ready = 1;
    bus.st_commit = 0;
    bus.flush = 0;
  endtask

  task automatic do_ld(input logic [31:0] base, input logic [31:0] imm,
                       input logic [2:0] f3, input logic [6:0] rd,
                       input logic [2:0] rob, input logic [31:0] want);
    for (int n = 0; n < 50 && !bus.ld_i_ready; n++) tick();
    bus.ld_i_valid = 1;
    bus.lsu_i_rs1_data = base;
    bus.lsu_i_imm = imm;
    bus.lsu_i_f3 = f3;
    bus.lsu_i_rd = rd;
    bus.lsu_i_rob_idx = rob;
    exp_q.push_back('{rob, rd, want});
    tick();
    bus.ld_i_valid = 0;
  endtask

  task automatic do_st(input logic [31:0] base, input logic [31:0] imm,
                       input logic [31:0] data, input logic [2:0] f3);
    for (int n = 0; n < 50 && !bus.st_i_ready; n++) tick();
    bus.st_i_valid = 1;
    bus.lsu_i_rs1_data = base;
    bus.lsu_i_imm = imm;
    bus.lsu_i_rs2_data = data;
    bus.lsu_i_f3 = f3;
    tick();
    bus.st_i_valid = 0;
  endtask

  task automatic do_commit;
    bus.st_commit = 1;
    tick();
    bus.st_commit = 0;
  endtask

  // Waits for a result; lat counts cycles from the accept cycle.
  task automatic wait_ld(output logic got, output ld_t obs, output int lat);
    got = 0;
    obs = '0;
    lat = 0;
    for (int n = 1; n < 60; n++) begin
      if (bus.ld_o_valid) begin
        got = 1;
        obs = '{bus.ld_o_rob_idx, bus.ld_o_rd, bus.ld_o_data};
        lat = n;
        tick();
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1;
    repeat (3) tick();
    checks++;
    if ({bus.ld_i_ready, bus.st_i_ready, bus.ld_o_valid,
         bus.dm_req, bus.dm_we} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=11000",
        {bus.ld_i_ready, bus.st_i_ready, bus.ld_o_valid,
         bus.dm_req, bus.dm_we});
    end
    checks++;
    if ({bus.ld_o_data, bus.ld_o_rd, bus.ld_o_rob_idx} !== 42'd0) begin
      failures++;
      $display("FAIL reset_ld_o got=%h want=0",
        {bus.ld_o_data, bus.ld_o_rd, bus.ld_o_rob_idx});
    end
    checks++;
    if ({bus.dm_addr, bus.dm_wstrb, bus.dm_wdata} !== 68'd0) begin
      failures++;
      $display("FAIL reset_dm got=%h want=0",
        {bus.dm_addr, bus.dm_wstrb, bus.dm_wdata});
    end
    rst = 0;
    tick();
  endtask

  task automatic test_forward;
    logic got;
    ld_t obs, e;
    wr_t w;
    int lat, r0;
    gnt_budget = 0;
    wr_q.delete();
    r0 = rd_total;
    do_st(32'hF0, 32'h10, 32'hDEADBEEF, 3'b010);
    do_commit();
    do_ld(32'h100, 32'h0, 3'b010, 7'd5, 3'd1, 32'hDEADBEEF);
    wait_ld(got, obs, lat);
    e = exp_q.pop_front();
    checks++;
    if (!got || obs !== e) begin
      failures++;
      $display("FAIL fwd_lw got=%h want=%h", obs, e);
    end
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL fwd_latency got=%0d want=2", lat);
    end
    checks++;
    if (rd_total !== r0) begin
      failures++;
      $display("FAIL fwd_no_read got=%0d want=%0d", rd_total, r0);
    end
    gnt_budget = 1000;
    repeat (5) tick();
    checks++;
    if (wr_q.size() !== 1) begin
      failures++;
      $display("FAIL fwd_drain_count got=%0d want=1", wr_q.size());
    end else begin
      w = wr_q.pop_front();
      checks++;
      if (w !== wr_t'({32'h100, 4'hF, 32'hDEADBEEF})) begin
        failures++;
        $display("FAIL fwd_drain got=%h want=%h", w,
          wr_t'({32'h100, 4'hF, 32'hDEADBEEF}));
      end
    end
  endtask

  task automatic test_byte_forward;
    logic got;
    ld_t obs, e;
    int lat;
    gnt_budget = 1000;
    wr_q.delete();
    do_st(32'h100, 32'h1, 32'h80, 3'b000);
    do_ld(32'h101, 32'h0, 3'b100, 7'd6, 3'd2, 32'h00000080);
    wait_ld(got, obs, lat);
    e = exp_q.pop_front();
    checks++;
    if (!got || obs !== e || lat !== 2) begin
      failures++;
      $display("FAIL lbu_fwd got=%h lat=%0d want=%h lat=2", obs, lat, e);
    end
    do_ld(32'h100, 32'h1, 3'b000, 7'd7, 3'd3, 32'hFFFFFF80);
    wait_ld(got, obs, lat);
    e = exp_q.pop_front();
    checks++;
    if (!got || obs !== e) begin
      failures++;
      $display("FAIL lb_fwd got=%h want=%h", obs, e);
    end
    bus.flush = 1;
    tick();
    bus.flush = 0;
    repeat (4) tick();
    checks++;
    if (wr_q.size() !== 0) begin
      failures++;
      $display("FAIL uncommitted_write got=%0d want=0", wr_q.size());
    end
  endtask

  task automatic test_partial_stall;
    logic got;
    ld_t obs, e;
    wr_t w, we;
    int lat;
    gnt_budget = 0;
    wr_q.delete();
    mem[32'h180 >> 2] = 32'h11223344;
    do_st(32'h180, 32'h2, 32'hAB, 3'b000);
    do_commit();
    do_ld(32'h180, 32'h0, 3'b010, 7'd8, 3'd4, 32'h11AB3344);
    repeat (3) tick();
    checks++;
    if (bus.ld_o_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_valid got=%b want=0", bus.ld_o_valid);
    end
    checks++;
    if ({bus.dm_req, bus.dm_we, bus.dm_wstrb, bus.dm_addr} !==
        {1'b1, 1'b1, 4'b0100, 32'h180}) begin
      failures++;
      $display("FAIL stall_drain_req got=%h want=%h",
        {bus.dm_req, bus.dm_we, bus.dm_wstrb, bus.dm_addr},
        {1'b1, 1'b1, 4'b0100, 32'h180});
    end
    gnt_budget = 1000;
    wait_ld(got, obs, lat);
    e = exp_q.pop_front();
    checks++;
    if (!got || obs !== e) begin
      failures++;
      $display("FAIL stall_lw got=%h want=%h", obs, e);
    end
    we = '{32'h180, 4'b0100, 32'h00AB0000};
    w = (wr_q.size() > 0) ? wr_q.pop_front() : '0;
    checks++;
    if (w !== we) begin
      failures++;
      $display("FAIL stall_write got=%h want=%h", w, we);
    end
  endtask

  task automatic test_full_wrap;
    wr_t w, we;
    gnt_budget = 0;
    wr_q.delete();
    wexp_q.delete();
    for (int k = 0; k < 4; k++) begin
      do_st(32'h400 + 32'(4 * k), 32'h0, 32'hA0000000 + 32'(k), 3'b010);
      wexp_q.push_back('{32'h400 + 32'(4 * k), 4'hF,
                         32'hA0000000 + 32'(k)});
    end
    checks++;
    if (bus.st_i_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready got=%b want=0", bus.st_i_ready);
    end
    bus.st_commit = 1;
    gnt_budget = 1;
    tick();
    bus.st_commit = 0;
    checks++;
    if (bus.st_i_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready_gnt_cycle got=%b want=0", bus.st_i_ready);
    end
    tick();
    checks++;
    if (bus.st_i_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_ready_after_pop got=%b want=1", bus.st_i_ready);
    end
    gnt_budget = 1000;
    repeat (3) do_commit();
    for (int k = 4; k < 12; k++) begin
      do_st(32'h400 + 32'(4 * k), 32'h0, 32'hA0000000 + 32'(k), 3'b010);
      wexp_q.push_back('{32'h400 + 32'(4 * k), 4'hF,
                         32'hA0000000 + 32'(k)});
      do_commit();
    end
    for (int n = 0; n < 100 && wr_q.size() < 12; n++) tick();
    checks++;
    if (wr_q.size() !== 12) begin
      failures++;
      $display("FAIL wrap_write_count got=%0d want=12", wr_q.size());
    end
    while (wr_q.size() > 0 && wexp_q.size() > 0) begin
      w = wr_q.pop_front();
      we = wexp_q.pop_front();
      checks++;
      if (w !== we) begin
        failures++;
        $display("FAIL wrap_write got=%h want=%h", w, we);
      end
    end
  endtask

  task automatic test_flush_sb;
    logic got;
    ld_t obs, e;
    wr_t w, we;
    int lat;
    gnt_budget = 0;
    wr_q.delete();
    mem[32'h510 >> 2] = 32'h55667788;
    do_st(32'h500, 32'h2, 32'hBEEF, 3'b001);
    do_st(32'h510, 32'h0, 32'h11, 3'b000);
    do_st(32'h520, 32'h0, 32'h12345678, 3'b010);
    bus.st_commit = 1;
    bus.flush = 1;
    tick();
    bus.st_commit = 0;
    bus.flush = 0;
    gnt_budget = 1000;
    repeat (8) tick();
    checks++;
    if (wr_q.size() !== 1) begin
      failures++;
      $display("FAIL flush_write_count got=%0d want=1", wr_q.size());
    end
    we = '{32'h500, 4'b1100, 32'hBEEF0000};
    w = (wr_q.size() > 0) ? wr_q.pop_front() : '0;
    checks++;
    if (w !== we) begin
      failures++;
      $display("FAIL flush_write got=%h want=%h", w, we);
    end
    do_ld(32'h510, 32'h0, 3'b100, 7'd9, 3'd5, 32'h00000088);
    wait_ld(got, obs, lat);
    e = exp_q.pop_front();
    checks++;
    if (!got || obs !== e || lat !== 4) begin
      failures++;
      $display("FAIL flush_sb_empty got=%h lat=%0d want=%h lat=4",
        obs, lat, e);
    end
  endtask

  task automatic test_hold_and_drop;
    logic got, seen;
    ld_t obs, e;
    int lat;
    gnt_budget = 1000;
    mem[32'h200 >> 2] = 32'h80011234;
    mem[32'h204 >> 2] = 32'h000000C3;
    bus.ld_o_ready = 0;
    do_ld(32'h200, 32'h2, 3'b001, 7'd10, 3'd6, 32'hFFFF8001);
    e = exp_q.pop_front();
    for (int n = 0; n < 20 && !bus.ld_o_valid; n++) tick();
    for (int c = 0; c < 3; c++) begin
      obs = '{bus.ld_o_rob_idx, bus.ld_o_rd, bus.ld_o_data};
      checks++;
      if (bus.ld_o_valid !== 1'b1 || obs !== e) begin
        failures++;
        $display("FAIL lh_hold cyc=%0d valid=%b got=%h want=%h",
          c, bus.ld_o_valid, obs, e);
      end
      tick();
    end
    bus.ld_o_ready = 1;
    tick();
    checks++;
    if (bus.ld_o_valid !== 1'b0) begin
      failures++;
      $display("FAIL lh_release got=%b want=0", bus.ld_o_valid);
    end
    rd_lat = 3;
    do_ld(32'h200, 32'h0, 3'b010, 7'd11, 3'd7, 32'h80011234);
    void'(exp_q.pop_back());
    repeat (2) tick();
    bus.flush = 1;
    tick();
    bus.flush = 0;
    checks++;
    if (bus.ld_i_ready !== 1'b0) begin
      failures++;
      $display("FAIL drop_state_ready got=%b want=0", bus.ld_i_ready);
    end
    seen = 0;
    repeat (5) begin
      if (bus.ld_o_valid) seen = 1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL drop_late_rvalid got=%b want=0", seen);
    end
    rd_lat = 1;
    do_ld(32'h204, 32'h0, 3'b100, 7'd12, 3'd0, 32'h000000C3);
    wait_ld(got, obs, lat);
    e = exp_q.pop_front();
    checks++;
    if (!got || obs !== e || lat !== 4) begin
      failures++;
      $display("FAIL after_drop got=%h lat=%0d want=%h lat=4",
        obs, lat, e);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_forward();
    test_byte_forward();
    test_partial_stall();
    test_full_wrap();
    test_flush_sb();
    test_hold_and_drop();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
